// File: rtl/i2c_target_rx_pkg.sv
// Shared definitions for the write-only I2C target: FSM states, bit positions
// and bus levels.
package i2c_target_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK1,
        ST_DATA1,
        ST_ACK2,
        ST_DATA2,
        ST_ACK3,
        ST_WAIT_STOP
    } rx_state_t;

    localparam int   RW_BIT     = 0;
    localparam logic ACK_LEVEL  = 1'b0;
    localparam logic NACK_LEVEL = 1'b1;

    // Open-drain pad: presenting a low level means enabling the pull-down.
    function automatic logic oe_for_level(input logic level);
        return level == ACK_LEVEL;
    endfunction

    // True while an address-matched frame is open but its word is not yet complete.
    function automatic logic mid_frame(input rx_state_t s);
        return (s == ST_ACK1) || (s == ST_DATA1) || (s == ST_ACK2) || (s == ST_DATA2);
    endfunction

endpackage

// File: rtl/i2c_target_rx_if.sv
// Bus and word-output bundle between the I2C target and whatever drives SCL/SDA.
interface i2c_target_rx_if;
    logic        i2c_sclk;
    logic        i2c_sdat_in;
    logic        sdat_oe;
    logic [15:0] data_out;
    logic        data_valid;
    logic        busy;
    logic        frame_err;

    modport master (
        output i2c_sclk, i2c_sdat_in,
        input  sdat_oe, data_out, data_valid, busy, frame_err
    );

    modport slave (
        input  i2c_sclk, i2c_sdat_in,
        output sdat_oe, data_out, data_valid, busy, frame_err
    );
endinterface

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer for one I2C line with registered rise/fall strobes.
// Optional stability filter enabled by I2C_RX_GLITCH_FILTER_EN.
module i2c_line_sync #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q;
    logic       clean;
    logic       prev_q;

    // Idle bus is high, so reset to 1 to avoid a false edge after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], line_in};
        end
    end

`ifdef I2C_RX_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic [CW-1:0] cnt_q;
    logic          filt_q;

    // Output follows the input only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else if (sync_q[1] != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_q <= sync_q[1];
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            cnt_q <= '0;
        end
    end

    assign clean = filt_q;
`else
    logic filter_len_unused;
    assign filter_len_unused = (FILTER_LEN > 0);
    assign clean = sync_q[1];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b1;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            prev_q <= clean;
            rise   <= clean & ~prev_q;
            fall   <= ~clean & prev_q;
        end
    end

    assign level = prev_q;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiving {addr+W, byte1, byte2} frames as a 16-bit word.
// Build option I2C_RX_GLITCH_FILTER_EN adds a stability filter on SCL and SDA.
module i2c_target_rx
    import i2c_target_rx_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = 7'h1A,
    parameter int         FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset_n,
    i2c_target_rx_if.slave bus
);

    logic scl_high, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_line_sync #(.FILTER_LEN(FILTER_LEN)) u_scl_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .line_in (bus.i2c_sclk),
        .level   (scl_high),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_line_sync #(.FILTER_LEN(FILTER_LEN)) u_sda_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .line_in (bus.i2c_sdat_in),
        .level   (sda_level),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    assign start_det = sda_fall & scl_high;
    assign stop_det  = sda_rise & scl_high;

    rx_state_t   state_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_cnt_q;
    logic        byte_full_q;
    logic [7:0]  byte1_q;
    logic        sdat_oe_q;
    logic [15:0] data_out_q;
    logic        data_valid_q;
    logic        busy_q;
    logic        frame_err_q;

    // START/STOP are checked before any SCL edge so bus conditions always win.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            byte_full_q  <= 1'b0;
            byte1_q      <= '0;
            sdat_oe_q    <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (start_det || stop_det) begin
                state_q     <= start_det ? ST_ADDR : ST_IDLE;
                bit_cnt_q   <= '0;
                byte_full_q <= 1'b0;
                sdat_oe_q   <= oe_for_level(NACK_LEVEL);
                busy_q      <= 1'b0;
                frame_err_q <= mid_frame(state_q);
            end else begin
                case (state_q)
                    ST_IDLE, ST_WAIT_STOP: begin
                        sdat_oe_q <= oe_for_level(NACK_LEVEL);
                    end
                    ST_ADDR, ST_DATA1, ST_DATA2: begin
                        if (scl_rise && !byte_full_q) begin
                            shift_q   <= {shift_q[6:0], sda_level};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                byte_full_q <= 1'b1;
                            end
                        end else if (scl_fall && byte_full_q) begin
                            byte_full_q <= 1'b0;
                            bit_cnt_q   <= '0;
                            case (state_q)
                                ST_ADDR: begin
                                    if (shift_q[7:1] == DEV_ADDR && shift_q[RW_BIT] == 1'b0) begin
                                        state_q   <= ST_ACK1;
                                        sdat_oe_q <= oe_for_level(ACK_LEVEL);
                                        busy_q    <= 1'b1;
                                    end else begin
                                        state_q <= ST_WAIT_STOP;
                                    end
                                end
                                ST_DATA1: begin
                                    byte1_q   <= shift_q;
                                    state_q   <= ST_ACK2;
                                    sdat_oe_q <= oe_for_level(ACK_LEVEL);
                                end
                                default: begin
                                    data_out_q   <= {byte1_q, shift_q};
                                    data_valid_q <= 1'b1;
                                    state_q      <= ST_ACK3;
                                    sdat_oe_q    <= oe_for_level(ACK_LEVEL);
                                end
                            endcase
                        end
                    end
                    ST_ACK1, ST_ACK2, ST_ACK3: begin
                        if (scl_fall) begin
                            sdat_oe_q <= oe_for_level(NACK_LEVEL);
                            case (state_q)
                                ST_ACK1: state_q <= ST_DATA1;
                                ST_ACK2: state_q <= ST_DATA2;
                                default: state_q <= ST_WAIT_STOP;
                            endcase
                        end
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        sdat_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sdat_oe    = sdat_oe_q;
    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.busy       = busy_q;
    assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: acts as the I2C master with an open-drain SDA
// and checks ACK slots, received words and error strobes against hand values.
module tb_i2c_target_rx;

    logic clk;
    logic reset_n;
    logic scl_drive;
    logic sda_drive;

    int check_count = 0;
    int fail_count  = 0;
    int valid_cycles = 0;
    int err_cycles   = 0;
    int oe_cycles    = 0;
    int busy_cycles  = 0;

    i2c_target_rx_if bus_if ();

    assign bus_if.i2c_sclk    = scl_drive;
    assign bus_if.i2c_sdat_in = sda_drive & ~bus_if.sdat_oe;

    i2c_target_rx #(.DEV_ADDR(7'h1A), .FILTER_LEN(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe and activity counters, sampled on the active edge.
    always @(posedge clk) begin
        if (bus_if.data_valid) valid_cycles++;
        if (bus_if.frame_err)  err_cycles++;
        if (bus_if.sdat_oe)    oe_cycles++;
        if (bus_if.busy)       busy_cycles++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_start();
        sda_drive = 1'b1;
        scl_drive = 1'b1;
        wait_clks(10);
        sda_drive = 1'b0;
        wait_clks(10);
        scl_drive = 1'b0;
        wait_clks(2);
    endtask

    task automatic send_rep_start();
        sda_drive = 1'b1;
        wait_clks(10);
        scl_drive = 1'b1;
        wait_clks(10);
        sda_drive = 1'b0;
        wait_clks(10);
        scl_drive = 1'b0;
        wait_clks(2);
    endtask

    task automatic send_stop();
        sda_drive = 1'b0;
        wait_clks(10);
        scl_drive = 1'b1;
        wait_clks(10);
        sda_drive = 1'b1;
        wait_clks(10);
    endtask

    task automatic send_bits(input logic [7:0] b, input int glitch_bit);
        for (int i = 7; i >= 0; i--) begin
            sda_drive = b[i];
            wait_clks(10);
            scl_drive = 1'b1;
            if (i == glitch_bit) begin
                wait_clks(4);
                scl_drive = 1'b0;
                wait_clks(2);
                scl_drive = 1'b1;
                wait_clks(4);
            end else begin
                wait_clks(10);
            end
            scl_drive = 1'b0;
            wait_clks(2);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int glitch_bit, output logic acked);
        send_bits(b, glitch_bit);
        sda_drive = 1'b1;
        wait_clks(10);
        scl_drive = 1'b1;
        wait_clks(5);
        acked = bus_if.sdat_oe;
        wait_clks(5);
        scl_drive = 1'b0;
        wait_clks(2);
    endtask

    task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] b1, input logic [7:0] b2,
                                 input int glitch_bit, output logic [2:0] acks);
        logic a;
        send_start();
        send_byte(addr, -1, a);
        acks[2] = a;
        send_byte(b1, glitch_bit, a);
        acks[1] = a;
        send_byte(b2, -1, a);
        acks[0] = a;
    endtask

    initial begin
        logic [2:0] acks;
        logic       a;
        int         oe_snap;
        int         busy_snap;

        reset_n   = 1'b0;
        scl_drive = 1'b1;
        sda_drive = 1'b1;
        wait_clks(4);
        checkOutput("rst_sdat_oe",    bus_if.sdat_oe,    0);
        checkOutput("rst_data_out",   bus_if.data_out,   16'h0000);
        checkOutput("rst_data_valid", bus_if.data_valid, 0);
        checkOutput("rst_busy",       bus_if.busy,       0);
        checkOutput("rst_frame_err",  bus_if.frame_err,  0);
        reset_n = 1'b1;
        wait_clks(10);

        $display("[TB] frame 0x34 / 0x1E / 0x00");
        applyStimulus(8'h34, 8'h1E, 8'h00, -1, acks);
        checkOutput("f1_acks",        acks,              3'b111);
        checkOutput("f1_busy_before", bus_if.busy,       1);
        send_stop();
        checkOutput("f1_data",        bus_if.data_out,   16'h1E00);
        checkOutput("f1_valid_cnt",   valid_cycles,      1);
        checkOutput("f1_err_cnt",     err_cycles,        0);
        checkOutput("f1_busy_after",  bus_if.busy,       0);
        checkOutput("f1_oe_after",    bus_if.sdat_oe,    0);

        $display("[TB] wrong address 0x36, then 0x34 / 0xAB / 0xCD");
        oe_snap   = oe_cycles;
        busy_snap = busy_cycles;
        applyStimulus(8'h36, 8'hAB, 8'hCD, -1, acks);
        send_stop();
        checkOutput("bad_addr_acks",  acks,                   3'b000);
        checkOutput("bad_addr_oe",    oe_cycles - oe_snap,    0);
        checkOutput("bad_addr_busy",  busy_cycles - busy_snap, 0);
        checkOutput("bad_addr_valid", valid_cycles,           1);
        checkOutput("bad_addr_data",  bus_if.data_out,        16'h1E00);
        applyStimulus(8'h34, 8'hAB, 8'hCD, -1, acks);
        send_stop();
        checkOutput("f2_acks",        acks,              3'b111);
        checkOutput("f2_data",        bus_if.data_out,   16'hABCD);
        checkOutput("f2_valid_cnt",   valid_cycles,      2);

        $display("[TB] read request 0x35");
        applyStimulus(8'h35, 8'h99, 8'h88, -1, acks);
        send_stop();
        checkOutput("rd_acks",        acks,              3'b000);
        checkOutput("rd_data",        bus_if.data_out,   16'hABCD);
        checkOutput("rd_valid_cnt",   valid_cycles,      2);

        $display("[TB] STOP after byte 1");
        send_start();
        send_byte(8'h34, -1, a);
        checkOutput("stop_ack_addr",  a, 1);
        send_byte(8'h55, -1, a);
        checkOutput("stop_ack_b1",    a, 1);
        send_stop();
        checkOutput("stop_err_cnt",   err_cycles,        1);
        checkOutput("stop_data",      bus_if.data_out,   16'hABCD);
        checkOutput("stop_valid_cnt", valid_cycles,      2);
        checkOutput("stop_busy",      bus_if.busy,       0);

        $display("[TB] repeated START after byte 1, then 0x34 / 0x12 / 0x34");
        send_start();
        send_byte(8'h34, -1, a);
        send_byte(8'h77, -1, a);
        send_rep_start();
        checkOutput("rs_err_cnt",     err_cycles,        2);
        checkOutput("rs_data_kept",   bus_if.data_out,   16'hABCD);
        send_byte(8'h34, -1, a);
        acks[2] = a;
        send_byte(8'h12, -1, a);
        acks[1] = a;
        send_byte(8'h34, -1, a);
        acks[0] = a;
        send_stop();
        checkOutput("rs_acks",        acks,              3'b111);
        checkOutput("rs_data",        bus_if.data_out,   16'h1234);
        checkOutput("rs_valid_cnt",   valid_cycles,      3);
        checkOutput("rs_err_final",   err_cycles,        2);

        $display("[TB] reset during ACK2");
        send_start();
        send_byte(8'h34, -1, a);
        send_bits(8'hA5, -1);
        sda_drive = 1'b1;
        wait_clks(10);
        scl_drive = 1'b1;
        wait_clks(3);
        checkOutput("ack2_oe_before", bus_if.sdat_oe, 1);
        checkOutput("ack2_busy",      bus_if.busy,    1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("ack2_rst_oe",    bus_if.sdat_oe,    0);
        checkOutput("ack2_rst_data",  bus_if.data_out,   16'h0000);
        checkOutput("ack2_rst_busy",  bus_if.busy,       0);
        checkOutput("ack2_rst_valid", bus_if.data_valid, 0);
        checkOutput("ack2_rst_err",   bus_if.frame_err,  0);
        wait_clks(3);
        reset_n = 1'b1;
        wait_clks(3);
        scl_drive = 1'b0;
        wait_clks(5);
        send_stop();
        checkOutput("post_rst_err",   err_cycles,        2);
        checkOutput("post_rst_data",  bus_if.data_out,   16'h0000);

`ifdef I2C_RX_GLITCH_FILTER_EN
        $display("[TB] SCL glitch during byte 1 with filter");
        applyStimulus(8'h34, 8'h5A, 8'hC3, 4, acks);
        send_stop();
        checkOutput("glitch_acks",    acks,              3'b111);
        checkOutput("glitch_data",    bus_if.data_out,   16'h5AC3);
        checkOutput("glitch_valid",   valid_cycles,      4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule

// File: doc/i2c_target_rx.md
# i2c_target_rx

Write-only I2C target (responder) that receives the two-byte configuration frames issued by the team's I2C master: START, 7-bit address + W, ACK, data byte 1, ACK, data byte 2, ACK, STOP. SCL and SDA are sampled on the system clock. The block ACKs only frames addressed to it, and presents each completed 16-bit word with a one-cycle strobe. It sits on the bus side opposite the master and serves as the bench model and loopback target for codec configuration traffic.

## Interface
- DEV_ADDR, 7'h1A, 7-bit target address that the block responds to.
- FILTER_LEN, 3, glitch-filter depth in clk cycles; used only when the filter macro is defined.
- clk  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i2c_sclk  in  1  bus SCL, asynchronous to clk.
- i2c_sdat_in  in  1  bus SDA as read back from the pad.
- sdat_oe  out  1  1 = pull SDA low (open-drain ACK), 0 = release SDA.
- data_out  out  16  last received word, {byte1, byte2}; held until the next complete frame.
- data_valid  out  1  one-cycle strobe when data_out updates.
- busy  out  1  high from an address-matched ACK until STOP or abort.
- frame_err  out  1  one-cycle strobe on a STOP or repeated START that arrives before byte 2 is acknowledged.

## Operation
- Both lines pass through a 2-FF synchronizer. Rising and falling SCL edges are then detected from the synchronized value.
- START: synchronized SDA falls while SCL is high. STOP: synchronized SDA rises while SCL is high. Both are recognized in every state.
- Data bits are sampled on SCL rising edges, MSB first, into an 8-bit shift register with a 3-bit bit counter.
- State machine:
  - IDLE: waits for START, then goes to ADDR.
  - ADDR: collects 8 bits. On the SCL falling edge after bit 8:
    - if addr[7:1]==DEV_ADDR and R/W==0, go to ACK1;
    - otherwise go to WAIT_STOP and do not ACK.
  - ACK1 → DATA1 → ACK2 → DATA2 → ACK3 → WAIT_STOP.
  - Each ACKn state drives sdat_oe=1 from the SCL falling edge after bit 8 until the next SCL falling edge.
  - WAIT_STOP: sdat_oe=0. Any further bytes get a NACK. The block leaves this state only on STOP or START.
- byte1 is latched when the FSM enters ACK2. On entry to ACK3, data_out ← {byte1, byte2} and data_valid pulses.
- A repeated START in any state goes to ADDR and clears the bit counter. A partial frame is discarded: data_out is unchanged. frame_err pulses if the FSM was busy and had not yet reached ACK3.
- A STOP in any state goes to IDLE. frame_err pulses if the FSM was in ACK1..DATA2.
- START and STOP outrank SCL edges that are detected in the same cycle.
- sdat_oe is never asserted outside ACK1/ACK2/ACK3.

## Timing
- Reset values: sdat_oe=0, data_out=16'h0000, data_valid=0, busy=0, frame_err=0, FSM=IDLE.
- Reset is asynchronous, so sdat_oe releases immediately, including mid-ACK.
- Input-to-detect latency: 2 sync cycles plus 1 edge-register cycle, i.e. 3 clk cycles from a pad transition to the START/STOP/edge strobe.
- sdat_oe changes 1 clk after the detected SCL falling edge. SCL low must last at least 5 clk cycles for the ACK to be valid before the next SCL rise.
- data_valid rises 1 clk after the detected 8th-bit SCL fall of byte 2, and is high for exactly 1 cycle.
- busy rises with sdat_oe at the start of ACK1 and falls 1 clk after STOP or abort is detected.

## Configuration
- I2C_RX_GLITCH_FILTER_EN defined: after synchronization, each line feeds a FILTER_LEN-deep stability filter. The filtered output changes only after FILTER_LEN consecutive equal samples, which adds FILTER_LEN cycles of latency to every detect.
- Not defined: the synchronized lines are used directly, giving 3-cycle latency, and FILTER_LEN is ignored.

## Structure
- Shared header i2c_states.vh: add target-side state constants (IDLE, ADDR, ACK1, DATA1, ACK2, DATA2, ACK3, WAIT_STOP) beside the master's states. The same header holds the R/W bit position and the ACK=0 / NACK=1 level constants.
- Sub-module i2c_line_sync (synchronizer, optional filter, rise/fall strobes), instantiated once for SCL and once for SDA.

## Test plan
- Frame addr 0x34 (0x1A+W), bytes 0x1E, 0x00, STOP → ACK on all three ACK slots, data_out=16'h1E00, data_valid pulses once, frame_err=0.
- Address 0x36 → sdat_oe stays 0 for the whole frame, no data_valid, busy=0; the next valid frame 0x34/0xAB/0xCD → 16'hABCD.
- Address 0x35 (R/W=1) → NACK, WAIT_STOP, data_out unchanged.
- STOP after byte 1 → frame_err pulses, data_out keeps its previous value, FSM=IDLE; a repeated START after byte 1 followed by a full frame 0x34/0x12/0x34 → frame_err pulses once, then 16'h1234 valid.
- reset_n low during ACK2 → sdat_oe=0 within the same cycle, all outputs at reset values.
- With I2C_RX_GLITCH_FILTER_EN, 2-cycle SCL glitches during DATA1 → no extra bits are shifted and the frame decodes correctly; without the macro, the same glitch corrupts byte 1.
